// File: rtl/i2f_ctl_if.sv
// i2f_ctl_if: issue-pipe request channel into the int-to-FP issue controller
//   valid/ready handshake; src = integer rs1, rm = instruction rounding mode,
//   fp64 = double destination, ctrl = {fcvt, fmv, sign, long}, tag = dest tag
interface i2f_ctl_if #(parameter int TAGW = 5);
    logic            valid;
    logic            ready;
    logic [63:0]     src;
    logic [2:0]      rm;
    logic            fp64;
    logic [3:0]      ctrl;
    logic [TAGW-1:0] tag;
    modport master (output valid, src, rm, fp64, ctrl, tag, input ready);
    modport slave  (input valid, src, rm, fp64, ctrl, tag, output ready);
endinterface

// File: rtl/i2f_ctl.sv
// i2f_ctl: two-stage issue controller for the integer-to-FP convert/move datapath
//   clk, rst_l                 clock, async active-low reset
//   i0, i1                     request pipes (i0 older, wins arbitration)
//   frm                        CSR dynamic rounding mode
//   flush                      kill all in-flight ops
//   dp_in1/dp_rm/dp_fp64/dp_ctrl  S1 operand stage driving the converter
//   dp_data, dp_exc            combinational converter result
//   wb_*                       S2 result stage with valid/ready backpressure
//   fflags, fflags_clr         sticky exception flags and their clear
//   busy                       any stage occupied
module i2f_ctl #(
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_l,
    i2f_ctl_if.slave        i0,
    i2f_ctl_if.slave        i1,
    input  logic [2:0]      frm,
    input  logic            flush,
    output logic [63:0]     dp_in1,
    output logic [2:0]      dp_rm,
    output logic            dp_fp64,
    output logic [3:0]      dp_ctrl,
    input  logic [64:0]     dp_data,
    input  logic [4:0]      dp_exc,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [64:0]     wb_data,
    output logic [4:0]      wb_exc,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_illegal,
    output logic [4:0]      fflags,
    input  logic            fflags_clr,
    output logic            busy
);
    localparam logic [2:0] RM_DYN = 3'b111;

    logic            s1_v_q, s1_v_d, s1_ill_q, s1_ill_d, dp_fp64_q, dp_fp64_d;
    logic [63:0]     dp_in1_q, dp_in1_d;
    logic [2:0]      dp_rm_q, dp_rm_d;
    logic [3:0]      dp_ctrl_q, dp_ctrl_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d, wb_tag_q, wb_tag_d;
    logic            s2_v_q, s2_v_d, wb_ill_q, wb_ill_d;
    logic [64:0]     wb_data_q, wb_data_d;
    logic [4:0]      wb_exc_q, wb_exc_d, fflags_q, fflags_d;
    logic            s2_free, s1_free, take0, take, adv, ill;
    logic [2:0]      rm_sel, rm_r;
    logic [3:0]      ctrl_sel;

    assign s2_free  = !s2_v_q | wb_ready;
    assign s1_free  = !s1_v_q | s2_free;
    assign i0.ready = s1_free & !flush;
    assign i1.ready = s1_free & !flush & !i0.valid;
    assign take0    = i0.valid & i0.ready;
    assign take     = take0 | (i1.valid & i1.ready);
    assign adv      = s1_v_q & s2_free;
    assign rm_sel   = take0 ? i0.rm : i1.rm;
    assign ctrl_sel = take0 ? i0.ctrl : i1.ctrl;
    assign rm_r     = (rm_sel == RM_DYN) ? frm : rm_sel;
    // exactly one of fcvt/fmv must be set; only conversions care about rm
    assign ill      = (ctrl_sel[3] == ctrl_sel[2]) | (ctrl_sel[3] & (rm_r >= 3'd5));

    always_comb begin
        s1_v_d    = !flush & (take | (s1_v_q & !s2_free));
        dp_in1_d  = take ? (take0 ? i0.src : i1.src) : dp_in1_q;
        dp_rm_d   = take ? rm_r : dp_rm_q;
        dp_fp64_d = take ? (take0 ? i0.fp64 : i1.fp64) : dp_fp64_q;
        // illegal ops present a null control so the converter idles at zero
        dp_ctrl_d = take ? (ill ? 4'b0 : ctrl_sel) : dp_ctrl_q;
        s1_tag_d  = take ? (take0 ? i0.tag : i1.tag) : s1_tag_q;
        s1_ill_d  = take ? ill : s1_ill_q;
        s2_v_d    = !flush & (adv | (s2_v_q & !wb_ready));
        wb_data_d = adv ? (s1_ill_q ? 65'b0 : dp_data) : wb_data_q;
        wb_exc_d  = adv ? (s1_ill_q ? 5'b0 : dp_exc) : wb_exc_q;
        wb_tag_d  = adv ? s1_tag_q : wb_tag_q;
        wb_ill_d  = adv ? s1_ill_q : wb_ill_q;
        // clear wins over a coincident handshake
        fflags_d  = fflags_clr ? 5'b0 : (s2_v_q & wb_ready) ? (fflags_q | wb_exc_q) : fflags_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_v_q    <= 1'b0;
            dp_in1_q  <= '0;
            dp_rm_q   <= '0;
            dp_fp64_q <= 1'b0;
            dp_ctrl_q <= '0;
            s1_tag_q  <= '0;
            s1_ill_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            wb_data_q <= '0;
            wb_exc_q  <= '0;
            wb_tag_q  <= '0;
            wb_ill_q  <= 1'b0;
            fflags_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            dp_in1_q  <= dp_in1_d;
            dp_rm_q   <= dp_rm_d;
            dp_fp64_q <= dp_fp64_d;
            dp_ctrl_q <= dp_ctrl_d;
            s1_tag_q  <= s1_tag_d;
            s1_ill_q  <= s1_ill_d;
            s2_v_q    <= s2_v_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            wb_tag_q  <= wb_tag_d;
            wb_ill_q  <= wb_ill_d;
            fflags_q  <= fflags_d;
        end
    end

    assign dp_in1     = dp_in1_q;
    assign dp_rm      = dp_rm_q;
    assign dp_fp64    = dp_fp64_q;
    assign dp_ctrl    = dp_ctrl_q;
    assign wb_valid   = s2_v_q;
    assign wb_data    = wb_data_q;
    assign wb_exc     = wb_exc_q;
    assign wb_tag     = wb_tag_q;
    assign wb_illegal = wb_ill_q;
    assign fflags     = fflags_q;
    assign busy       = s1_v_q | s2_v_q;
endmodule

// File: tb/tb_i2f_ctl.sv
// tb_i2f_ctl: directed self-checking bench for i2f_ctl with a stub converter
module tb_i2f_ctl;
    localparam int TAGW = 5;

    logic            clk = 1'b0, rst_l = 1'b0;
    logic [2:0]      frm;
    logic            flush, wb_ready, fflags_clr;
    logic [63:0]     dp_in1;
    logic [2:0]      dp_rm;
    logic            dp_fp64;
    logic [3:0]      dp_ctrl;
    logic [64:0]     dp_data;
    logic [4:0]      dp_exc;
    logic            wb_valid, wb_illegal, busy;
    logic [64:0]     wb_data;
    logic [4:0]      wb_exc, fflags;
    logic [TAGW-1:0] wb_tag;
    int              n_chk = 0, n_err = 0;

    i2f_ctl_if #(.TAGW(TAGW)) i0_if ();
    i2f_ctl_if #(.TAGW(TAGW)) i1_if ();

    i2f_ctl #(.TAGW(TAGW)) dut (
        .clk(clk), .rst_l(rst_l), .i0(i0_if), .i1(i1_if), .frm(frm), .flush(flush),
        .dp_in1(dp_in1), .dp_rm(dp_rm), .dp_fp64(dp_fp64), .dp_ctrl(dp_ctrl),
        .dp_data(dp_data), .dp_exc(dp_exc), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_exc(wb_exc), .wb_tag(wb_tag), .wb_illegal(wb_illegal),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // stub converter: result encodes operand and controls, flags are src[4:0]
    function automatic logic [64:0] conv(input logic [63:0] s, input logic [3:0] c,
                                         input logic [2:0] r, input logic f);
        return {f, s ^ {56'h0, c, 1'b0, r}};
    endfunction

    assign dp_data = conv(dp_in1, dp_ctrl, dp_rm, dp_fp64);
    assign dp_exc  = dp_in1[4:0];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [63:0] s, input logic [2:0] r, input logic [3:0] c,
                          input logic [TAGW-1:0] t, input logic f);
        i0_if.valid = 1'b1;
        i0_if.src   = s;
        i0_if.rm    = r;
        i0_if.ctrl  = c;
        i0_if.tag   = t;
        i0_if.fp64  = f;
    endtask

    task automatic send_op(input logic [63:0] s, input logic [2:0] r, input logic [3:0] c,
                           input logic [TAGW-1:0] t, input logic f);
        bit ok = 0;
        drive0(s, r, c, t, f);
        #1;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (i0_if.ready) ok = 1;
            tick();
        end
        i0_if.valid = 1'b0;
        chk("send_acc", ok, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30 && busy; k++) tick();
        chk("idle_to", busy, 0);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_wbv"}, wb_valid, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_ff"}, fflags, 0);
        chk({p, "_dpin"}, dp_in1, 0);
        chk({p, "_dprm"}, dp_rm, 0);
        chk({p, "_dpfp"}, dp_fp64, 0);
        chk({p, "_dpctl"}, dp_ctrl, 0);
        chk({p, "_wbd"}, wb_data, 0);
        chk({p, "_wbe"}, wb_exc, 0);
        chk({p, "_wbt"}, wb_tag, 0);
        chk({p, "_wbi"}, wb_illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent, got, first, last;
        i0_if.valid = 0; i0_if.src = 0; i0_if.rm = 0; i0_if.ctrl = 0; i0_if.tag = 0; i0_if.fp64 = 0;
        i1_if.valid = 0; i1_if.src = 0; i1_if.rm = 0; i1_if.ctrl = 0; i1_if.tag = 0; i1_if.fp64 = 0;
        frm = 0; flush = 0; wb_ready = 1; fflags_clr = 0;
        #3;
        chk_reset_vals("rst");
        #9 rst_l = 1'b1;
        tick();
        chk("rst_i0rdy", i0_if.ready, 1);
        chk("rst_i1rdy", i1_if.ready, 1);
        i0_if.valid = 1'b1;
        #1;
        chk("rst_i1rdy_blk", i1_if.ready, 0);
        i0_if.valid = 1'b0;
        tick();

        // single op
        send_op(64'd1, 3'd0, 4'b1010, 5'd3, 1'b0);
        chk("one_dpin", dp_in1, 1);
        chk("one_dpctl", dp_ctrl, 4'b1010);
        chk("one_wbv0", wb_valid, 0);
        tick();
        chk("one_wbv", wb_valid, 1);
        chk("one_data", wb_data, conv(64'd1, 4'b1010, 3'd0, 1'b0));
        chk("one_tag", wb_tag, 3);
        chk("one_ill", wb_illegal, 0);
        chk("one_exc", wb_exc, 5'b00001);
        tick();
        chk("one_drain", wb_valid, 0);
        chk("one_ff", fflags, 5'b00001);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("clr_ff", fflags, 0);

        // arbitration
        drive0(64'h100, 3'd1, 4'b1010, 5'd4, 1'b0);
        i1_if.valid = 1; i1_if.src = 64'h200; i1_if.rm = 3'd3; i1_if.ctrl = 4'b1011;
        i1_if.tag = 5'd5; i1_if.fp64 = 1'b1;
        #1;
        chk("arb_i0rdy", i0_if.ready, 1);
        chk("arb_i1rdy", i1_if.ready, 0);
        tick();
        i0_if.valid = 1'b0;
        #1;
        chk("arb_i1rdy2", i1_if.ready, 1);
        chk("arb_dp0", dp_in1, 64'h100);
        tick();
        i1_if.valid = 1'b0;
        chk("arb_tag0", wb_tag, 4);
        chk("arb_data0", wb_data, conv(64'h100, 4'b1010, 3'd1, 1'b0));
        chk("arb_dp1", dp_in1, 64'h200);
        chk("arb_fp1", dp_fp64, 1);
        tick();
        chk("arb_tag1", wb_tag, 5);
        chk("arb_data1", wb_data, conv(64'h200, 4'b1011, 3'd3, 1'b1));
        tick();
        chk("arb_drain", wb_valid, 0);

        // dynamic rounding and illegal encodings
        frm = 3'd2;
        send_op(64'h300, 3'd7, 4'b1010, 5'd6, 1'b0);
        chk("dyn_rm", dp_rm, 2);
        tick();
        chk("dyn_data", wb_data, conv(64'h300, 4'b1010, 3'd2, 1'b0));
        chk("dyn_ill", wb_illegal, 0);
        frm = 3'd5;
        send_op(64'h305, 3'd7, 4'b1010, 5'd7, 1'b0);
        chk("ill_dpctl", dp_ctrl, 0);
        tick();
        chk("ill_flag", wb_illegal, 1);
        chk("ill_data", wb_data, 0);
        chk("ill_exc", wb_exc, 0);
        chk("ill_tag", wb_tag, 7);
        send_op(64'h400, 3'd7, 4'b0100, 5'd9, 1'b1);
        chk("fmv_rm", dp_rm, 5);
        tick();
        chk("fmv_ill", wb_illegal, 0);
        chk("fmv_data", wb_data, conv(64'h400, 4'b0100, 3'd5, 1'b1));
        send_op(64'h500, 3'd0, 4'b1100, 5'd10, 1'b0);
        tick();
        chk("ill_both", wb_illegal, 1);
        wait_idle();
        chk("ill_noff", fflags, 0);
        frm = 3'd0;

        // backpressure: 4 back-to-back ops, writeback stalled 5 cycles
        sent = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 15; c++) begin
            wb_ready = (c >= 5);
            if (sent < 4) drive0(64'h1000 * (sent + 1), 3'd0, 4'b1010, 5'(8 + sent), 1'b0);
            else i0_if.valid = 1'b0;
            #1;
            if (c == 2) chk("bp_rdy2", i0_if.ready, 0);
            if (c == 4) begin
                chk("bp_sent", sent, 2);
                chk("bp_rdy4", i0_if.ready, 0);
                chk("bp_hold_tag", wb_tag, 8);
                chk("bp_hold_dp", dp_in1, 64'h2000);
                chk("bp_wbv", wb_valid, 1);
            end
            if (wb_valid && wb_ready) begin
                chk("bp_tag", wb_tag, 8 + got);
                chk("bp_data", wb_data, conv(64'h1000 * (got + 1), 4'b1010, 3'd0, 1'b0));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (i0_if.valid && i0_if.ready) sent++;
            tick();
        end
        i0_if.valid = 1'b0;
        wb_ready = 1'b1;
        chk("bp_got", got, 4);
        chk("bp_allsent", sent, 4);
        chk("bp_rate", last - first, 3);

        // fflags accumulation and clear priority
        send_op(64'h001, 3'd0, 4'b1010, 5'd12, 1'b0);
        send_op(64'h010, 3'd0, 4'b1010, 5'd13, 1'b0);
        wait_idle();
        chk("ff_or", fflags, 5'b10001);
        send_op(64'h004, 3'd0, 4'b1010, 5'd14, 1'b0);
        tick();
        chk("ff_wbv", wb_valid, 1);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("ff_clrpri", fflags, 0);
        chk("ff_hs", wb_valid, 0);

        // flush while a writeback handshake completes
        send_op(64'h002, 3'd0, 4'b1010, 5'd15, 1'b0);
        tick();
        drive0(64'h008, 3'd0, 4'b1010, 5'd20, 1'b0);
        flush = 1'b1;
        #1;
        chk("flh_rdy", i0_if.ready, 0);
        tick();
        flush = 1'b0;
        i0_if.valid = 1'b0;
        chk("flh_ff", fflags, 5'b00010);
        chk("flh_busy", busy, 0);

        // flush with both stages full and writeback stalled
        wb_ready = 1'b0;
        send_op(64'h008, 3'd0, 4'b1010, 5'd16, 1'b0);
        send_op(64'h001, 3'd0, 4'b1010, 5'd17, 1'b0);
        chk("fls_full", i0_if.ready, 0);
        chk("fls_wbv", wb_valid, 1);
        drive0(64'h004, 3'd0, 4'b1010, 5'd21, 1'b0);
        flush = 1'b1;
        #1;
        chk("fls_rdy", i0_if.ready, 0);
        tick();
        flush = 1'b0;
        i0_if.valid = 1'b0;
        chk("fls_wbv0", wb_valid, 0);
        chk("fls_busy", busy, 0);
        chk("fls_ff", fflags, 5'b00010);
        tick();
        chk("fls_noacc", busy, 0);

        // asynchronous reset mid-stream
        send_op(64'h003, 3'd1, 4'b1010, 5'd18, 1'b0);
        tick();
        chk("arst_pre", wb_valid, 1);
        #2 rst_l = 1'b0;
        #1;
        chk_reset_vals("arst");
        #3 rst_l = 1'b1;
        wb_ready = 1'b1;
        tick();
        chk("arst_rdy", i0_if.ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/i2f_ctl.md
# i2f_ctl

Issue controller for the integer-to-FP conversion/move datapath in the FPU. Arbitrates conversion and move requests from the two issue pipes (i0 older than i1), resolves dynamic rounding, and flags illegal encodings. Drives the combinational converter from an operand stage and captures its result into a writeback stage with valid/ready backpressure. Also accumulates a sticky exception-flag register for the FPU CSR logic.

## Interface
- TAGW, 5, width of destination-register tag carried with each op
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- i0_valid / i1_valid  in  1  request valid, pipe 0 / pipe 1
- i0_ready / i1_ready  out  1  request accepted when valid & ready
- i0_src / i1_src  in  64  integer rs1 operand
- i0_rm / i1_rm  in  3  instruction rounding mode (3'b111 = dynamic)
- i0_fp64 / i1_fp64  in  1  1 = double destination, 0 = single
- i0_ctrl / i1_ctrl  in  4  {fcvt, fmv, sign, long}
- i0_tag / i1_tag  in  TAGW  destination tag
- frm  in  3  CSR dynamic rounding mode
- flush  in  1  kill all in-flight ops
- dp_in1  out  64  converter operand
- dp_rm  out  3  resolved rounding mode
- dp_fp64  out  1  converter precision select
- dp_ctrl  out  4  converter control code
- dp_data  in  65  converter recoded result (combinational from dp_*)
- dp_exc  in  5  converter exception flags
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback accepts result
- wb_data  out  65  recoded result
- wb_exc  out  5  exception flags of this op
- wb_tag  out  TAGW  destination tag
- wb_illegal  out  1  op had illegal encoding
- fflags  out  5  sticky OR of wb_exc over completed ops
- fflags_clr  in  1  clear fflags
- busy  out  1  S1 or S2 valid

## Operation
- Two stages: S1 (operand register, drives dp_*), S2 (result register, drives wb_*).
- Advance: s2_free = !s2_v | wb_ready. S1 moves to S2 when s1_v & s2_free. s1_free = !s1_v | s2_free.
- Arbitration: fixed priority. i0_ready = s1_free & !flush. i1_ready = s1_free & !flush & !i0_valid. At most one request accepted per cycle.
- RM resolution at capture: rm_r = (rm==3'b111) ? frm : rm.
- Illegal when: fcvt==fmv (both or neither set), or fcvt & rm_r in {5,6,7}. fmv ops never check rm.
- Illegal op: S1 captures dp_ctrl=4'b0, so the converter outputs zero. S2 captures wb_data=0 and wb_exc=0 with wb_illegal=1. Still consumes one slot and a handshake.
- Legal op: S2 captures dp_data and dp_exc, with wb_illegal=0.
- wb_tag follows its op through S1 and S2.
- fflags: on each wb_valid & wb_ready, fflags |= wb_exc.
  - fflags_clr has priority over OR-in in the same cycle (result 0; that op's flags are lost).
- flush:
  - Next cycle, s1_v=0 and s2_v=0, and no request is accepted in the flush cycle.
  - A wb handshake occurring in the flush cycle still completes and updates fflags.
  - Flushed ops never update fflags.
- busy = s1_v | s2_v.

## Timing
- Reset, all asynchronous:
  - s1_v=0, s2_v=0, wb_valid=0, busy=0, fflags=0.
  - dp_in1=0, dp_rm=0, dp_fp64=0, dp_ctrl=0.
  - wb_data=0, wb_exc=0, wb_tag=0, wb_illegal=0.
  - i0_ready=1 and i1_ready=!i0_valid once rst_l is high and flush=0.
- Latency: request accepted at edge N drives dp_* after N. Result is registered at N+1, so wb_valid is high after edge N+1.
- Throughput: 1 op/cycle with wb_ready held high.
- Backpressure: with wb_ready=0 and both stages full, i*_ready=0.
  - wb_* and dp_* hold stable while stalled.
  - wb_valid never drops without a handshake or flush.
- Full pipe with wb_ready=1: S2 drains, S1 advances and a new op is accepted, all in the same cycle (no bubble).
- Reset mid-operation: all valids clear immediately, and in-flight ops are lost.
- dp_* change only on S1 capture. Outputs are registered, with no combinational path from i* to wb_*.

## Test plan
- Single op: i0 fcvt.s.w, src=32'd1, rm=0, ctrl=4'b1010, tag=3 -> wb_valid 2 cycles later, wb_data=converter result for 1.0f, wb_tag=3, wb_illegal=0.
- Arbitration: i0 and i1 valid together for 1 cycle -> only i0 accepted, i1_ready=0. i1 accepted next cycle, and results appear in order i0 then i1.
- Dynamic rm: i0_rm=7, frm=3'd2 -> dp_rm=2. frm=3'd5 with fcvt -> wb_illegal=1, wb_data=0, wb_exc=0. Same op with fmv (ctrl=4'b0100) -> legal.
- Backpressure: 4 back-to-back ops with wb_ready=0 for 5 cycles -> 2 ops held in S1/S2 and ready deasserted. Release gives 4 results in order, one per cycle, none dropped or duplicated.
- fflags: ops returning dp_exc=5'b00001 then 5'b10000 -> fflags=5'b10001. fflags_clr coincident with a handshake carrying 5'b00100 -> fflags=0.
- Flush/reset: flush with both stages full and wb_ready=0 -> wb_valid=0 and busy=0 next cycle, fflags unchanged, request in flush cycle not accepted. rst_l low mid-stream -> all outputs at reset values asynchronously.
